// File: rtl/o_f_bank_ctrl.sv
// N-bank ping-pong output-feature buffer: packs CLP beats into the current write bank,
// closes banks on command or when full, and serves registered processor reads until release.
module o_f_bank_ctrl #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 8192,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W    = ADDR_W + 1,
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       state,
    input  logic                       CLP_output_flag,
    input  logic [DATA_W-1:0]          feature_i,
    input  logic                       bank_close,
    output logic                       wr_ready,
    output logic [BANK_W-1:0]          wr_bank,
    output logic                       overflow,
    input  logic                       arm_read_feature_enable,
    input  logic [BANK_W-1:0]          arm_read_feature_select,
    input  logic [ADDR_W-1:0]          arm_read_feature_addr,
    output logic [DATA_W-1:0]          arm_read_feature_data,
    output logic                       arm_read_feature_valid,
    input  logic                       arm_release,
    input  logic [BANK_W-1:0]          arm_release_select,
    output logic [NUM_BANKS-1:0]       bank_full,
    output logic [NUM_BANKS*CNT_W-1:0] bank_count
);

    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              drop;
    logic              do_close;
    logic [CNT_W-1:0]  close_cnt;
    logic [BANK_W-1:0] next_bank;
    logic [31:0]       rd_sel_ext;
    logic [31:0]       rel_sel_ext;

    // Write-side decode; a close counts a beat landing in the same cycle.
    always_comb begin
        wr_ready    = ~bank_full[wr_bank];
        wr_en       = state & CLP_output_flag & wr_ready;
        drop        = state & CLP_output_flag & ~wr_ready;
        do_close    = wr_ready &
                      ((bank_close & ((wr_ptr != '0) | wr_en)) |
                       (wr_en & (wr_ptr == ADDR_W'(DEPTH - 1))));
        close_cnt   = CNT_W'(wr_ptr) + CNT_W'(wr_en);
        next_bank   = (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank + BANK_W'(1);
        rd_sel_ext  = 32'(arm_read_feature_select);
        rel_sel_ext = 32'(arm_release_select);
    end

    // Bank storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_ptr] <= feature_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank                <= '0;
            wr_ptr                 <= '0;
            bank_full              <= '0;
            bank_count             <= '0;
            overflow               <= 1'b0;
            arm_read_feature_data  <= '0;
            arm_read_feature_valid <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            // Release only touches full banks, so it never collides with the bank being closed.
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (arm_release && (rel_sel_ext == 32'(b)) && bank_full[b]) begin
                    bank_full[b]                  <= 1'b0;
                    bank_count[b*CNT_W +: CNT_W]  <= '0;
                end
                if (do_close && (wr_bank == BANK_W'(b))) begin
                    bank_full[b]                  <= 1'b1;
                    bank_count[b*CNT_W +: CNT_W]  <= close_cnt;
                end
            end
            if (do_close) begin
                wr_ptr  <= '0;
                wr_bank <= next_bank;
            end
            arm_read_feature_valid <= arm_read_feature_enable;
            if (arm_read_feature_enable) begin
                arm_read_feature_data <= (rd_sel_ext < NUM_BANKS)
                    ? mem[arm_read_feature_select][arm_read_feature_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_o_f_bank_ctrl.sv
// Directed bench for o_f_bank_ctrl: a 2-bank and a 4-bank instance (DEPTH=16) sharing stimulus,
// each held in reset while the other is exercised.
module tb_o_f_bank_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst4;
    logic         state;
    logic         flag;
    logic [127:0] feature;
    logic         bank_close;
    logic         rd_en;
    logic [1:0]   rd_sel;
    logic [3:0]   rd_addr;
    logic         arm_release;
    logic [1:0]   rel_sel;

    logic         wr_ready2, overflow2, valid2;
    logic [0:0]   wr_bank2;
    logic [127:0] data2;
    logic [1:0]   full2;
    logic [9:0]   count2;

    logic         wr_ready4, overflow4, valid4;
    logic [1:0]   wr_bank4;
    logic [127:0] data4;
    logic [3:0]   full4;
    logic [19:0]  count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    o_f_bank_ctrl #(.NUM_BANKS(2), .DATA_W(128), .DEPTH(16)) dut2 (
        .clk(clk), .rst(rst), .state(state), .CLP_output_flag(flag), .feature_i(feature),
        .bank_close(bank_close), .wr_ready(wr_ready2), .wr_bank(wr_bank2), .overflow(overflow2),
        .arm_read_feature_enable(rd_en), .arm_read_feature_select(rd_sel[0:0]),
        .arm_read_feature_addr(rd_addr), .arm_read_feature_data(data2),
        .arm_read_feature_valid(valid2), .arm_release(arm_release),
        .arm_release_select(rel_sel[0:0]), .bank_full(full2), .bank_count(count2)
    );

    o_f_bank_ctrl #(.NUM_BANKS(4), .DATA_W(128), .DEPTH(16)) dut4 (
        .clk(clk), .rst(rst4), .state(state), .CLP_output_flag(flag), .feature_i(feature),
        .bank_close(bank_close), .wr_ready(wr_ready4), .wr_bank(wr_bank4), .overflow(overflow4),
        .arm_read_feature_enable(rd_en), .arm_read_feature_select(rd_sel),
        .arm_read_feature_addr(rd_addr), .arm_read_feature_data(data4),
        .arm_read_feature_valid(valid4), .arm_release(arm_release),
        .arm_release_select(rel_sel), .bank_full(full4), .bank_count(count4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [127:0] d, input logic cl);
        flag = 1'b1; feature = d; bank_close = cl;
        cyc();
        flag = 1'b0; bank_close = 1'b0;
    endtask

    task automatic close_bank();
        bank_close = 1'b1;
        cyc();
        bank_close = 1'b0;
    endtask

    task automatic release_bank(input int b);
        arm_release = 1'b1; rel_sel = 2'(b);
        cyc();
        arm_release = 1'b0;
    endtask

    task automatic rd(input int b, input int a);
        rd_en = 1'b1; rd_sel = 2'(b); rd_addr = 4'(a);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1; state = 1'b0; flag = 1'b0; feature = '0; bank_close = 1'b0;
        rd_en = 1'b0; rd_sel = '0; rd_addr = '0; arm_release = 1'b0; rel_sel = '0;
        cyc(); cyc();

        // Reset values
        check("rst_full", 128'(full2), 128'h0);
        check("rst_count", 128'(count2), 128'h0);
        check("rst_wr_bank", 128'(wr_bank2), 128'h0);
        check("rst_ready", 128'(wr_ready2), 128'h1);
        check("rst_data_valid", {data2[126:0], valid2}, 128'h0);
        rst = 1'b0; state = 1'b1;
        cyc();

        // T1: five beats then close, read back
        for (int i = 1; i <= 5; i++) put(128'(i), 1'b0);
        close_bank();
        check("t1_full", 128'(full2), 128'h1);
        check("t1_count0", 128'(count2[4:0]), 128'd5);
        check("t1_wr_bank", 128'(wr_bank2), 128'h1);
        for (int i = 0; i < 5; i++) begin
            rd(0, i);
            check("t1_valid", 128'(valid2), 128'h1);
            check("t1_data", data2, 128'(i + 1));
        end
        cyc();
        check("t1_valid_drop", 128'(valid2), 128'h0);
        check("t1_data_hold", data2, 128'h5);

        // T2: auto-close on the 16th beat
        do_reset();
        for (int i = 0; i < 16; i++) put(128'(32'h100 + i), 1'b0);
        check("t2_full", 128'(full2), 128'h1);
        check("t2_count0", 128'(count2[4:0]), 128'd16);
        check("t2_wr_bank", 128'(wr_bank2), 128'h1);
        check("t2_overflow", 128'(overflow2), 128'h0);
        rd(0, 15);
        check("t2_last", data2, 128'h10f);

        // T3: both banks full, drop, release bank0
        for (int i = 0; i < 3; i++) put(128'(32'h200 + i), 1'b0);
        close_bank();
        check("t3_full", 128'(full2), 128'h3);
        check("t3_count1", 128'(count2[9:5]), 128'd3);
        check("t3_ready", 128'(wr_ready2), 128'h0);
        put(128'hdead, 1'b0);
        check("t3_overflow", 128'(overflow2), 128'h1);
        check("t3_full_kept", 128'(full2), 128'h3);
        rd(0, 0);
        check("t3_b0_intact", data2, 128'h100);
        release_bank(0);
        check("t3_ready_rel", 128'(wr_ready2), 128'h1);
        check("t3_full_rel", 128'(full2), 128'h2);
        check("t3_count0_rel", 128'(count2[4:0]), 128'd0);
        put(128'hbeef, 1'b1);
        rd(0, 0);
        check("t3_new_beat", data2, 128'hbeef);
        check("t3_count0_new", 128'(count2[4:0]), 128'd1);
        check("t3_overflow_sticky", 128'(overflow2), 128'h1);

        // Strobe while idle is ignored, and an empty close does nothing
        do_reset();
        state = 1'b0;
        put(128'h55, 1'b0);
        close_bank();
        check("idle_full", 128'(full2), 128'h0);
        check("idle_overflow", 128'(overflow2), 128'h0);
        state = 1'b1;

        // T4: close on the third beat, then an empty close
        do_reset();
        put(128'h31, 1'b0);
        put(128'h32, 1'b0);
        put(128'h33, 1'b1);
        check("t4_count0", 128'(count2[4:0]), 128'd3);
        check("t4_wr_bank", 128'(wr_bank2), 128'h1);
        close_bank();
        check("t4_empty_full", 128'(full2), 128'h1);
        check("t4_empty_bank", 128'(wr_bank2), 128'h1);
        // Same-cycle write and read of bank1 addr0 returns the older 0x200
        flag = 1'b1; feature = 128'h44; rd_en = 1'b1; rd_sel = 2'd1; rd_addr = 4'd0;
        cyc();
        flag = 1'b0; rd_en = 1'b0;
        check("t4_no_bypass", data2, 128'h200);
        rd(1, 0);
        check("t4_after_write", data2, 128'h44);

        // T5: async reset mid-burst
        do_reset();
        for (int i = 0; i < 16; i++) put(128'(32'h500 + i), 1'b0);
        for (int i = 0; i < 7; i++) put(128'(32'h600 + i), 1'b0);
        rd(0, 3);
        check("t5_pre_read", data2, 128'h503);
        flag = 1'b1; feature = 128'h6ff;
        #2 rst = 1'b1;
        #1;
        check("t5_full", 128'(full2), 128'h0);
        check("t5_count", 128'(count2), 128'h0);
        check("t5_wr_bank", 128'(wr_bank2), 128'h0);
        check("t5_data", data2, 128'h0);
        check("t5_ready", 128'(wr_ready2), 128'h1);
        flag = 1'b0;
        @(negedge clk) rst = 1'b0;
        cyc();
        put(128'h77, 1'b1);
        rd(0, 0);
        check("t5_first", data2, 128'h77);
        check("t5_count0", 128'(count2[4:0]), 128'd1);

        // T6: four banks, out-of-order release
        rst = 1'b1; rst4 = 1'b0;
        cyc();
        for (int b = 0; b < 4; b++) put(128'(32'h400 + b), 1'b1);
        check("t6_full", 128'(full4), 128'hf);
        check("t6_ready", 128'(wr_ready4), 128'h0);
        check("t6_wr_bank", 128'(wr_bank4), 128'h0);
        check("t6_count3", 128'(count4[19:15]), 128'd1);
        release_bank(2);
        check("t6_full_rel2", 128'(full4), 128'hb);
        check("t6_ready_rel2", 128'(wr_ready4), 128'h0);
        put(128'h4ee, 1'b0);
        check("t6_overflow", 128'(overflow4), 128'h1);
        release_bank(0);
        check("t6_ready_rel0", 128'(wr_ready4), 128'h1);
        put(128'h4aa, 1'b1);
        check("t6_wr_bank_next", 128'(wr_bank4), 128'h1);
        rd(0, 0);
        check("t6_b0", data4, 128'h4aa);
        rd(3, 0);
        check("t6_b3", data4, 128'h403);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
